// File: rtl/mac_issue_sequencer.sv
// Issue sequencer for one C = A x B multiply: walks (i, j, k) with k innermost,
// and carries the indices down a valid pipeline so they line up with product_reg.
module mac_issue_sequencer #(
   parameter int M          = 4,
   parameter int K          = 4,
   parameter int N          = 4,
   parameter int PIPE_DELAY = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 hold,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en_ab,
   output logic [$clog2(M)-1:0] row_addr_a,
   output logic [$clog2(K)-1:0] col_addr_a,
   output logic [$clog2(K)-1:0] row_addr_b,
   output logic [$clog2(N)-1:0] col_addr_b,
   output logic                 mult_done_reg,
   output logic [$clog2(M)-1:0] matrix_a_row_addr_counter_reg,
   output logic [$clog2(K)-1:0] matrix_a_col_addr_counter_reg,
   output logic [$clog2(K)-1:0] matrix_b_row_addr_counter_reg,
   output logic [$clog2(N)-1:0] matrix_b_col_addr_counter_reg
);

   localparam int IW = $clog2(M);
   localparam int KW = $clog2(K);
   localparam int JW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state;
   logic [IW-1:0] i_cnt;
   logic [KW-1:0] k_cnt;
   logic [JW-1:0] j_cnt;

   logic                  pv [PIPE_DELAY];
   logic [IW-1:0]         pi [PIPE_DELAY];
   logic [KW-1:0]         pk [PIPE_DELAY];
   logic [JW-1:0]         pj [PIPE_DELAY];

   logic i_last;
   logic j_last;
   logic k_last;
   logic up_v;

   assign i_last = (i_cnt == IW'(M - 1));
   assign j_last = (j_cnt == JW'(N - 1));
   assign k_last = (k_cnt == KW'(K - 1));

   // Anything still ahead of the product register keeps DRAIN waiting.
   always_comb begin
      up_v = rd_en_ab;
      for (int n = 0; n < PIPE_DELAY - 1; n++) begin
         up_v = up_v | pv[n];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_en_ab   <= 1'b0;
         row_addr_a <= '0;
         col_addr_a <= '0;
         row_addr_b <= '0;
         col_addr_b <= '0;
         i_cnt      <= '0;
         j_cnt      <= '0;
         k_cnt      <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               rd_en_ab <= 1'b0;
               done     <= 1'b0;
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                  i_cnt <= '0;
                  j_cnt <= '0;
                  k_cnt <= '0;
               end
            end
            S_RUN: begin
               rd_en_ab <= ~hold;
               if (!hold) begin
                  row_addr_a <= i_cnt;
                  col_addr_a <= k_cnt;
                  row_addr_b <= k_cnt;
                  col_addr_b <= j_cnt;
                  if (k_last) begin
                     k_cnt <= '0;
                     if (j_last) begin
                        j_cnt <= '0;
                        if (i_last) begin
                           state <= S_DRAIN;
                        end else begin
                           i_cnt <= i_cnt + 1'b1;
                        end
                     end else begin
                        j_cnt <= j_cnt + 1'b1;
                     end
                  end else begin
                     k_cnt <= k_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               rd_en_ab <= 1'b0;
               if (!up_v) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Indices load only with a valid entry, so bubbles never disturb them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < PIPE_DELAY; n++) begin
            pv[n] <= 1'b0;
            pi[n] <= '0;
            pk[n] <= '0;
            pj[n] <= '0;
         end
      end else begin
         pv[0] <= rd_en_ab;
         if (rd_en_ab) begin
            pi[0] <= row_addr_a;
            pk[0] <= col_addr_a;
            pj[0] <= col_addr_b;
         end
         for (int n = 1; n < PIPE_DELAY; n++) begin
            pv[n] <= pv[n-1];
            if (pv[n-1]) begin
               pi[n] <= pi[n-1];
               pk[n] <= pk[n-1];
               pj[n] <= pj[n-1];
            end
         end
      end
   end

   assign mult_done_reg                 = pv[PIPE_DELAY-1];
   assign matrix_a_row_addr_counter_reg = pi[PIPE_DELAY-1];
   assign matrix_a_col_addr_counter_reg = pk[PIPE_DELAY-1];
   assign matrix_b_row_addr_counter_reg = pk[PIPE_DELAY-1];
   assign matrix_b_col_addr_counter_reg = pj[PIPE_DELAY-1];

endmodule

// File: tb/tb_mac_issue_sequencer.sv
// Bench for mac_issue_sequencer: a 4x4x4 and a 3x5x2 instance against an
// issue-count model, plus literal timing/count expectations per scenario.
module tb_mac_issue_sequencer;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic start0 = 1'b0;
   logic hold0  = 1'b0;
   logic start1 = 1'b0;
   logic hold1  = 1'b0;

   logic       b0_busy, b0_done, b0_rd, b0_md;
   logic [1:0] b0_ra, b0_ca, b0_rb, b0_cb;
   logic [1:0] b0_ci, b0_ck, b0_ckb, b0_cj;

   logic       b1_busy, b1_done, b1_rd, b1_md;
   logic [1:0] b1_ra, b1_ci;
   logic [2:0] b1_ca, b1_rb, b1_ck, b1_ckb;
   logic [0:0] b1_cb, b1_cj;

   always #5 clk = ~clk;

   mac_issue_sequencer #(.M(4), .K(4), .N(4), .PIPE_DELAY(2)) dut0 (
      .clk(clk), .resetn(resetn), .start(start0), .hold(hold0),
      .busy(b0_busy), .done(b0_done), .rd_en_ab(b0_rd),
      .row_addr_a(b0_ra), .col_addr_a(b0_ca),
      .row_addr_b(b0_rb), .col_addr_b(b0_cb),
      .mult_done_reg(b0_md),
      .matrix_a_row_addr_counter_reg(b0_ci),
      .matrix_a_col_addr_counter_reg(b0_ck),
      .matrix_b_row_addr_counter_reg(b0_ckb),
      .matrix_b_col_addr_counter_reg(b0_cj)
   );

   mac_issue_sequencer #(.M(3), .K(5), .N(2), .PIPE_DELAY(2)) dut1 (
      .clk(clk), .resetn(resetn), .start(start1), .hold(hold1),
      .busy(b1_busy), .done(b1_done), .rd_en_ab(b1_rd),
      .row_addr_a(b1_ra), .col_addr_a(b1_ca),
      .row_addr_b(b1_rb), .col_addr_b(b1_cb),
      .mult_done_reg(b1_md),
      .matrix_a_row_addr_counter_reg(b1_ci),
      .matrix_a_col_addr_counter_reg(b1_ck),
      .matrix_b_row_addr_counter_reg(b1_ckb),
      .matrix_b_col_addr_counter_reg(b1_cj)
   );

   localparam int D = 2;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input int u, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s u%0d cyc %0d: got %0d expected %0d", nm, u, cyc, act, exp);
      end
   endtask

   function automatic int dm(input int u); return (u == 0) ? 4 : 3; endfunction
   function automatic int dk(input int u); return (u == 0) ? 4 : 5; endfunction
   function automatic int dn(input int u); return (u == 0) ? 4 : 2; endfunction

   // Model: issue number n maps to (i, j, k) by k-innermost row-major order.
   bit m_issuing [2];
   int m_iss [2];
   int m_prod [2];
   bit m_busy [2];
   bit m_done [2];
   bit m_md [2];
   bit m_rd [2];
   int m_ai [2];
   int m_ak [2];
   int m_aj [2];
   int m_ci [2];
   int m_ck [2];
   int m_cj [2];
   bit hv [2][D+1];
   int hn [2][D+1];

   task automatic model_reset(input int u);
      m_issuing[u] = 0; m_iss[u] = 0; m_prod[u] = 0;
      m_busy[u] = 0; m_done[u] = 0; m_md[u] = 0; m_rd[u] = 0;
      m_ai[u] = 0; m_ak[u] = 0; m_aj[u] = 0;
      m_ci[u] = 0; m_ck[u] = 0; m_cj[u] = 0;
      for (int s = 0; s <= D; s++) begin
         hv[u][s] = 0;
         hn[u][s] = 0;
      end
   endtask

   task automatic step(input int u, input bit st, input bit hd);
      int  tot;
      bit  old_done;
      bit  v_new;
      int  n_new;
      tot      = dm(u) * dk(u) * dn(u);
      old_done = m_done[u];
      m_done[u] = m_md[u] && (m_prod[u] == tot);
      v_new = 0;
      n_new = 0;
      if (m_issuing[u] && !hd) begin
         v_new = 1;
         n_new = m_iss[u];
         m_iss[u]++;
         if (m_iss[u] == tot) m_issuing[u] = 0;
         m_ai[u] = n_new / (dn(u) * dk(u));
         m_aj[u] = (n_new / dk(u)) % dn(u);
         m_ak[u] = n_new % dk(u);
      end
      m_rd[u] = v_new;
      if (!m_busy[u] && st) begin
         m_issuing[u] = 1;
         m_iss[u]     = 0;
         m_prod[u]    = 0;
         m_busy[u]    = 1;
      end else if (m_busy[u] && old_done) begin
         m_busy[u] = 0;
      end
      for (int s = D; s >= 1; s--) begin
         hv[u][s] = hv[u][s-1];
         hn[u][s] = hn[u][s-1];
      end
      hv[u][0] = v_new;
      hn[u][0] = n_new;
      m_md[u]  = hv[u][D];
      if (m_md[u]) begin
         m_prod[u]++;
         m_ci[u] = hn[u][D] / (dn(u) * dk(u));
         m_cj[u] = (hn[u][D] / dk(u)) % dn(u);
         m_ck[u] = hn[u][D] % dk(u);
      end
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         model_reset(0);
         model_reset(1);
      end else begin
         step(0, start0, hold0);
         step(1, start1, hold1);
      end
   end

   always @(posedge clk) cyc++;

   // Observed stats per unit, cleared at each start.
   int rd_cnt [2];
   int md_cnt [2];
   int done_cnt [2];
   int first_rd [2];
   int first_md [2];
   int done_cyc [2];
   int f_i [2];
   int f_j [2];
   int f_k [2];
   int l_i [2];
   int l_j [2];
   int l_k [2];
   int bub_cnt = 0;
   bit stall_chk = 0;

   task automatic clear_stats(input int u);
      rd_cnt[u] = 0; md_cnt[u] = 0; done_cnt[u] = 0;
      first_rd[u] = -1; first_md[u] = -1; done_cyc[u] = -1;
      f_i[u] = -1; f_j[u] = -1; f_k[u] = -1;
      l_i[u] = -1; l_j[u] = -1; l_k[u] = -1;
   endtask

   task automatic observe(input int u);
      int busy, done, rd, ra, ca, rb, cb, md, ci, ck, ckb, cj;
      if (u == 0) begin
         busy = int'(b0_busy); done = int'(b0_done); rd = int'(b0_rd);
         ra = int'(b0_ra); ca = int'(b0_ca); rb = int'(b0_rb); cb = int'(b0_cb);
         md = int'(b0_md); ci = int'(b0_ci); ck = int'(b0_ck);
         ckb = int'(b0_ckb); cj = int'(b0_cj);
      end else begin
         busy = int'(b1_busy); done = int'(b1_done); rd = int'(b1_rd);
         ra = int'(b1_ra); ca = int'(b1_ca); rb = int'(b1_rb); cb = int'(b1_cb);
         md = int'(b1_md); ci = int'(b1_ci); ck = int'(b1_ck);
         ckb = int'(b1_ckb); cj = int'(b1_cj);
      end
      chk("busy", u, busy, int'(m_busy[u]));
      chk("done", u, done, int'(m_done[u]));
      chk("rd_en_ab", u, rd, int'(m_rd[u]));
      chk("row_addr_a", u, ra, m_ai[u]);
      chk("col_addr_a", u, ca, m_ak[u]);
      chk("row_addr_b", u, rb, m_ak[u]);
      chk("col_addr_b", u, cb, m_aj[u]);
      chk("mult_done_reg", u, md, int'(m_md[u]));
      chk("a_row_ctr", u, ci, m_ci[u]);
      chk("a_col_ctr", u, ck, m_ck[u]);
      chk("b_row_ctr", u, ckb, m_ck[u]);
      chk("b_col_ctr", u, cj, m_cj[u]);
      if (rd != 0) begin
         rd_cnt[u]++;
         if (first_rd[u] < 0) first_rd[u] = cyc;
      end
      if (md != 0) begin
         md_cnt[u]++;
         if (first_md[u] < 0) begin
            first_md[u] = cyc;
            f_i[u] = ci; f_j[u] = cj; f_k[u] = ck;
         end
         l_i[u] = ci; l_j[u] = cj; l_k[u] = ck;
      end
      if (done != 0) begin
         done_cnt[u]++;
         done_cyc[u] = cyc;
      end
      if (u == 0 && stall_chk && md == 0 && md_cnt[0] == 6 && busy != 0) begin
         bub_cnt++;
         chk("bubble_ctr_i", 0, ci, 0);
         chk("bubble_ctr_j", 0, cj, 1);
         chk("bubble_ctr_k", 0, ck, 1);
      end
   endtask

   always @(negedge clk) begin
      observe(0);
      observe(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int u, input int lim);
      int t;
      t = 0;
      while (done_cnt[u] == 0 && t < lim) begin
         tick();
         t++;
      end
      if (done_cnt[u] == 0) chk("done_timeout", u, 0, 1);
   endtask

   task automatic wait_rd(input int u, input int n, input int lim);
      int t;
      t = 0;
      while (rd_cnt[u] < n && t < lim) begin
         tick();
         t++;
      end
      if (rd_cnt[u] < n) chk("issue_timeout", u, rd_cnt[u], n);
   endtask

   int c0;

   initial begin
      clear_stats(0);
      clear_stats(1);
      repeat (3) tick();
      chk("rst_busy", 0, int'(b0_busy), 0);
      chk("rst_rd", 0, int'(b0_rd), 0);
      chk("rst_md", 0, int'(b0_md), 0);
      chk("rst_done", 0, int'(b0_done), 0);
      resetn = 1'b1;
      repeat (2) tick();

      // Basic 4x4x4 run
      clear_stats(0);
      c0 = cyc;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 200);
      chk("A_issues", 0, rd_cnt[0], 64);
      chk("A_products", 0, md_cnt[0], 64);
      chk("A_first_issue", 0, first_rd[0] - c0, 2);
      chk("A_first_prod", 0, first_md[0] - c0, 4);
      chk("A_done_time", 0, done_cyc[0] - c0, 68);
      chk("A_first_ijk", 0, f_i[0] * 100 + f_j[0] * 10 + f_k[0], 0);
      chk("A_last_ijk", 0, l_i[0] * 100 + l_j[0] * 10 + l_k[0], 333);
      repeat (3) tick();
      chk("A_done_pulses", 0, done_cnt[0], 1);
      chk("A_idle_busy", 0, int'(b0_busy), 0);

      // Stall of 3 cycles after the 6th issue
      clear_stats(0);
      bub_cnt = 0;
      stall_chk = 1;
      c0 = cyc;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_rd(0, 6, 20);
      hold0 = 1'b1;
      repeat (3) tick();
      hold0 = 1'b0;
      wait_done(0, 200);
      stall_chk = 0;
      chk("B_issues", 0, rd_cnt[0], 64);
      chk("B_products", 0, md_cnt[0], 64);
      chk("B_done_time", 0, done_cyc[0] - c0, 71);
      chk("B_bubbles", 0, bub_cnt, 3);
      repeat (3) tick();

      // 3x5x2 instance
      clear_stats(1);
      c0 = cyc;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(1, 100);
      chk("C_issues", 1, rd_cnt[1], 30);
      chk("C_products", 1, md_cnt[1], 30);
      chk("C_done_time", 1, done_cyc[1] - c0, 34);
      chk("C_first_ijk", 1, f_i[1] * 100 + f_j[1] * 10 + f_k[1], 0);
      chk("C_last_ijk", 1, l_i[1] * 100 + l_j[1] * 10 + l_k[1], 214);
      repeat (3) tick();
      chk("C_done_pulses", 1, done_cnt[1], 1);

      // Reset mid-run
      clear_stats(0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_rd(0, 20, 40);
      resetn = 1'b0;
      #1;
      chk("D_rst_busy", 0, int'(b0_busy), 0);
      chk("D_rst_rd", 0, int'(b0_rd), 0);
      chk("D_rst_md", 0, int'(b0_md), 0);
      chk("D_rst_addr", 0, int'({b0_ra, b0_ca, b0_rb, b0_cb}), 0);
      chk("D_rst_ctr", 0, int'({b0_ci, b0_ck, b0_ckb, b0_cj}), 0);
      repeat (2) tick();
      resetn = 1'b1;
      repeat (5) tick();
      chk("D_no_done", 0, done_cnt[0], 0);
      clear_stats(0);
      c0 = cyc;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 200);
      chk("D_products", 0, md_cnt[0], 64);
      chk("D_first_ijk", 0, f_i[0] * 100 + f_j[0] * 10 + f_k[0], 0);
      chk("D_done_time", 0, done_cyc[0] - c0, 68);
      repeat (3) tick();

      // Starts while busy and in DRAIN are ignored; start right after done runs again
      clear_stats(0);
      c0 = cyc;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (10) tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_rd(0, 64, 100);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 50);
      chk("E_products", 0, md_cnt[0], 64);
      chk("E_done_time", 0, done_cyc[0] - c0, 68);
      tick();
      chk("E_idle_busy", 0, int'(b0_busy), 0);
      clear_stats(0);
      c0 = cyc;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 200);
      chk("E2_first_issue", 0, first_rd[0] - c0, 2);
      chk("E2_products", 0, md_cnt[0], 64);
      chk("E2_done_time", 0, done_cyc[0] - c0, 68);
      repeat (3) tick();
      chk("E2_done_pulses", 0, done_cnt[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
